uart_status_tx: RTL and testbench
=================================

Name: uart_status_tx

Overview:
- RS232 transmitter that reports the generator's current settings back to the host.
- It is the return path for the control receiver that sets waveform and phase-increment ("adder") values.
- On a `send` request it snapshots `wf` and `adder`, builds a 7-byte status frame and serialises it as UART 8N1 on `tx`.
- Runs in the 200 MHz generator clock domain alongside the control receiver.

Parameters:
- CLK_DIV, 1736, clock cycles per UART bit (200 MHz / 115200 baud); legal range >= 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock (200 MHz)
- rst  input  1  asynchronous, active-high reset
- wf  input  8  current waveform code
- adder  input  32  current phase-accumulator increment
- send  input  1  request: transmit one status frame (sampled each clk)
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse when the frame's final stop bit completes

Behaviour:
- Reset (asynchronous, active-high):
  - tx=1, busy=0, done=0.
  - FSM=IDLE, bit counter=0, byte index=0, baud counter=0.
  - Reset asserted mid-frame forces tx high immediately. The frame is abandoned, not resumed.
- Frame content (bytes in order):
  - B0 = SYNC_BYTE
  - B1 = wf
  - B2 = adder[31:24]
  - B3 = adder[23:16]
  - B4 = adder[15:8]
  - B5 = adder[7:0]
  - B6 = checksum = (B1+B2+B3+B4+B5) mod 256, an 8-bit truncated sum that excludes the sync byte.
- Snapshot: wf and adder are latched, and the checksum is computed, in the cycle `send` is accepted. Later input changes do not affect the frame in flight.
- Byte format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit holds for exactly CLK_DIV clk cycles.
  - Bytes are sent back to back with no extra idle gap.
  - Frame length = 70*CLK_DIV cycles.
- FSM states:
  - IDLE -> START on `send`=1.
  - START (CLK_DIV cycles, tx=0) -> DATA.
  - DATA (8 bits, shifting out the byte LSB first) -> STOP.
  - STOP (CLK_DIV cycles, tx=1) -> START of the next byte if byte index < 6; otherwise -> IDLE with `done` asserted.
- Acceptance and timing:
  - `send` is accepted only in IDLE. While busy=1, `send` is ignored; there is no queuing.
  - When `send` is sampled high in IDLE at edge N, tx=0 and busy=1 are both registered outputs, valid from edge N+1.
- Completion:
  - At the final edge of B6's stop bit, busy falls and `done` pulses high for exactly one cycle.
  - `send` held high in that same cycle is not accepted. The earliest acceptance is the next cycle, when the FSM is in IDLE.
  - `send` held continuously therefore produces frames separated by exactly one idle clk.
- tx is driven from a register, with no combinational path from inputs.
- The baud counter counts 0..CLK_DIV-1 and wraps. The bit counter counts 0..7. The byte index counts 0..6.

Test Plan:
1. Reset behaviour:
   - Stimulus: CLK_DIV=4; assert rst, then release with send=0 for 100 cycles.
   - Required: tx=1, busy=0, done=0 throughout.
2. Basic frame:
   - Stimulus: CLK_DIV=4, wf=8'h03, adder=32'h12345678, pulse send one cycle.
   - Required: bytes A5 03 12 34 56 78 17 decoded from tx; each bit exactly 4 cycles wide; busy high for 280 cycles; done pulses once at cycle 280 after acceptance.
3. Checksum wrap:
   - Stimulus: wf=8'hFF, adder=32'hFFFFFFFF, send.
   - Required: checksum byte = 8'hFB.
4. Snapshot and ignored send:
   - Stimulus: start a frame with wf=8'h01, adder=32'h0; change wf to 8'h05 and pulse send mid-frame.
   - Required: frame carries wf=01 with checksum 01; no second frame follows; busy drops after 280 cycles.
5. Back-to-back frames:
   - Stimulus: hold send=1 continuously.
   - Required: consecutive frames separated by exactly one idle cycle (tx=1, busy=0); done pulses once per frame.
6. Reset mid-frame:
   - Stimulus: assert rst during the DATA bits of B3, then release; send a new request.
   - Required: tx goes high asynchronously; busy=0 with no done pulse; the next send produces a complete, correct frame starting with A5.

Source files
------------

// File: rtl/uart_status_tx.sv
// uart_status_tx: snapshots waveform code and phase increment on request and
// sends them back to the host as a 7-byte UART 8N1 status frame.
// Frame: SYNC, wf, adder[31:24], adder[23:16], adder[15:8], adder[7:0], checksum.
module uart_status_tx #(
  parameter int unsigned CLK_DIV   = 1736,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  wf,
  input  logic [31:0] adder,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0] LAST_BYTE = 3'd6;
  localparam logic [2:0] LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [2:0]         byte_q, byte_d;
  logic [7:0]         wf_q, wf_d;
  logic [31:0]        adder_q, adder_d;
  logic [7:0]         ck_q, ck_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [7:0]         cur_byte;
  logic [2:0]         bit_nxt;
  logic               baud_end;

  // Select the frame byte currently being serialised.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = wf_q;
      3'd2:    cur_byte = adder_q[31:24];
      3'd3:    cur_byte = adder_q[23:16];
      3'd4:    cur_byte = adder_q[15:8];
      3'd5:    cur_byte = adder_q[7:0];
      default: cur_byte = ck_q;
    endcase
  end

  assign bit_nxt  = bit_q + 3'd1;
  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    wf_d    = wf_q;
    adder_d = adder_q;
    ck_d    = ck_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (send) begin
          // Snapshot inputs so later changes cannot corrupt the frame in flight.
          wf_d    = wf;
          adder_d = adder;
          ck_d    = wf + adder[31:24] + adder[23:16] + adder[15:8] + adder[7:0];
          state_d = START;
          baud_d  = '0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            byte_d  = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      wf_q    <= 8'd0;
      adder_q <= 32'd0;
      ck_q    <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      wf_q    <= wf_d;
      adder_q <= adder_d;
      ck_q    <= ck_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Testbench for uart_status_tx: frame content, bit timing, busy/done, snapshot,
// back-to-back frames and asynchronous reset, against a frame-level model.
module tb_uart_status_tx;

  localparam int DIV   = 4;
  localparam int BYTEC = 10 * DIV;   // cycles per byte on the line
  localparam int FRAME = 70 * DIV;   // cycles per frame
  localparam int PER   = FRAME + 1;  // frame plus the single idle cycle
  localparam int MAXN  = 1200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wf;
  logic [31:0] adder;
  logic        send;
  logic        tx, busy, done;

  int checks = 0;
  int errors = 0;

  logic obs_tx   [MAXN];
  logic obs_busy [MAXN];
  logic obs_done [MAXN];

  uart_status_tx #(.CLK_DIV(DIV), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .wf(wf), .adder(adder), .send(send),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame bytes packed with B0 in the low byte.
  function automatic logic [55:0] make_frame(input logic [7:0] w, input logic [31:0] a);
    int s;
    s = int'(w) + int'(a[31:24]) + int'(a[23:16]) + int'(a[15:8]) + int'(a[7:0]);
    return {8'(s % 256), a[7:0], a[15:8], a[23:16], a[31:24], w, 8'hA5};
  endfunction

  // Line level at cycle m within a frame: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [55:0] f, input int m);
    int b, p;
    b = m / BYTEC;
    p = (m % BYTEC) / DIV;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return f[b*8 + p - 1];
  endfunction

  // Expected tx(0)/busy(1)/done(2) at sample m when nf frames start every PER cycles.
  function automatic logic exp_sig(input int kind, input logic [55:0] f, input int nf, input int m);
    int k, r;
    logic in_frame;
    k = m / PER;
    r = m % PER;
    in_frame = (k < nf) && (r < FRAME);
    case (kind)
      0:       return in_frame ? frame_bit(f, r) : 1'b1;
      1:       return in_frame;
      default: return (k < nf) && (r == FRAME);
    endcase
  endfunction

  // Index of first sample differing from the model, or -1.
  function automatic int first_bad(input int kind, input logic [55:0] f, input int nf, input int len);
    logic o;
    for (int m = 0; m < len; m++) begin
      o = (kind == 0) ? obs_tx[m] : (kind == 1) ? obs_busy[m] : obs_done[m];
      if (o !== exp_sig(kind, f, nf, m)) return m;
    end
    return -1;
  endfunction

  // Decode 7 bytes from the captured line by sampling mid-bit.
  function automatic logic [55:0] decode(input int base);
    logic [55:0] d;
    d = '0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 8; j++)
        d[i*8 + j] = obs_tx[base + i*BYTEC + (j+1)*DIV + DIV/2];
    return d;
  endfunction

  function automatic int count_ones(input int kind, input int len);
    int c;
    c = 0;
    for (int m = 0; m < len; m++)
      c += ((kind == 1) ? obs_busy[m] : obs_done[m]) ? 1 : 0;
    return c;
  endfunction

  // Raise send, then record one sample per cycle; sample 0 follows the accepting edge.
  task automatic capture(input int len, input bit hold, input int poke);
    @(negedge clk);
    send = 1'b1;
    for (int m = 0; m < len; m++) begin
      @(negedge clk);
      obs_tx[m]   = tx;
      obs_busy[m] = busy;
      obs_done[m] = done;
      if (!hold && m == 0) send = 1'b0;
      if (m == poke) begin
        wf   = 8'h05;
        send = 1'b1;
      end else if (poke >= 0 && m == poke + 1) begin
        send = 1'b0;
      end
    end
    send = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1; send = 1'b0; wf = 8'h00; adder = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hold: tx/busy/done=%b required 100", {tx, busy, done});
    end
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({tx, busy, done} !== 3'b100) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_idle: %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_basic;
    logic [55:0] f, d;
    int i;
    wf = 8'h03; adder = 32'h12345678;
    capture(300, 1'b0, -1);
    f = make_frame(8'h03, 32'h12345678);
    d = decode(0);
    checks++;
    if (d !== 56'h17_78_56_34_12_03_A5) begin
      errors++;
      $display("FAIL basic_bytes: got %h required %h", d, 56'h17_78_56_34_12_03_A5);
    end
    i = first_bad(0, f, 1, 300);
    checks++;
    if (i !== -1) begin
      errors++;
      $display("FAIL basic_tx_timing: tx=%b at sample %0d required %b", obs_tx[i], i, exp_sig(0, f, 1, i));
    end
    i = count_ones(1, 300);
    checks++;
    if (i !== FRAME) begin
      errors++;
      $display("FAIL basic_busy_len: %0d cycles required %0d", i, FRAME);
    end
    i = first_bad(2, f, 1, 300);
    checks++;
    if (i !== -1 || count_ones(2, 300) !== 1) begin
      errors++;
      $display("FAIL basic_done: first wrong sample %0d pulses %0d required pulse only at %0d", i, count_ones(2, 300), FRAME);
    end
  endtask

  task automatic test_checksum_wrap;
    logic [55:0] d;
    int i;
    wf = 8'hFF; adder = 32'hFFFFFFFF;
    capture(290, 1'b0, -1);
    d = decode(0);
    checks++;
    if (d[55:48] !== 8'hFB) begin
      errors++;
      $display("FAIL checksum_wrap: got %h required fb", d[55:48]);
    end
    i = first_bad(0, make_frame(8'hFF, 32'hFFFFFFFF), 1, 290);
    checks++;
    if (i !== -1) begin
      errors++;
      $display("FAIL checksum_wrap_tx: mismatch at sample %0d", i);
    end
  endtask

  task automatic test_snapshot;
    logic [55:0] f, d;
    int i;
    wf = 8'h01; adder = 32'h0;
    capture(400, 1'b0, 50);
    f = make_frame(8'h01, 32'h0);
    d = decode(0);
    checks++;
    if (d[15:8] !== 8'h01 || d[55:48] !== 8'h01) begin
      errors++;
      $display("FAIL snapshot_bytes: wf=%h ck=%h required 01 01", d[15:8], d[55:48]);
    end
    i = first_bad(0, f, 1, 400);
    checks++;
    if (i !== -1) begin
      errors++;
      $display("FAIL snapshot_tx: mismatch at sample %0d (second frame or corruption)", i);
    end
    i = first_bad(1, f, 1, 400);
    checks++;
    if (i !== -1) begin
      errors++;
      $display("FAIL snapshot_busy: busy=%b at sample %0d", obs_busy[i], i);
    end
  endtask

  task automatic test_random_frames;
    logic [55:0] f;
    int i;
    for (int n = 0; n < 4; n++) begin
      wf = 8'($urandom); adder = $urandom;
      f = make_frame(wf, adder);
      capture(290, 1'b0, -1);
      i = first_bad(0, f, 1, 290);
      checks++;
      if (i !== -1) begin
        errors++;
        $display("FAIL random_tx[%0d]: wf=%h adder=%h mismatch at sample %0d", n, f[15:8], adder, i);
      end
      i = first_bad(1, f, 1, 290);
      checks++;
      if (i !== -1) begin
        errors++;
        $display("FAIL random_busy[%0d]: busy=%b at sample %0d", n, obs_busy[i], i);
      end
      i = first_bad(2, f, 1, 290);
      checks++;
      if (i !== -1) begin
        errors++;
        $display("FAIL random_done[%0d]: done=%b at sample %0d", n, obs_done[i], i);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [55:0] f;
    int i;
    wf = 8'($urandom); adder = $urandom;
    f = make_frame(wf, adder);
    capture(3*PER, 1'b1, -1);
    i = first_bad(0, f, 3, 3*PER);
    checks++;
    if (i !== -1) begin
      errors++;
      $display("FAIL b2b_tx: tx=%b at sample %0d required %b", obs_tx[i], i, exp_sig(0, f, 3, i));
    end
    i = first_bad(1, f, 3, 3*PER);
    checks++;
    if (i !== -1) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b at sample %0d", obs_busy[i], i);
    end
    i = count_ones(2, 3*PER);
    checks++;
    if (i !== 3 || first_bad(2, f, 3, 3*PER) !== -1) begin
      errors++;
      $display("FAIL b2b_done: %0d pulses required 3 at frame ends", i);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [55:0] f, d;
    int bad, i;
    wf = 8'($urandom); adder = {8'($urandom), 8'h00, 16'($urandom)};
    @(negedge clk);
    send = 1'b1;
    for (int m = 0; m <= 130; m++) begin
      @(negedge clk);
      if (m == 0) send = 1'b0;
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre: tx=%b busy=%b required 0 1", tx, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL midframe_async: tx/busy/done=%b required 100", {tx, busy, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if ({tx, busy, done} !== 3'b100) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midframe_abandon: %0d non-idle cycles required 0", bad);
    end
    wf = 8'h3C; adder = 32'hA1B2C3D4;
    f = make_frame(8'h3C, 32'hA1B2C3D4);
    capture(290, 1'b0, -1);
    d = decode(0);
    i = first_bad(0, f, 1, 290);
    checks++;
    if (d !== f || i !== -1) begin
      errors++;
      $display("FAIL midframe_recover: bytes %h required %h, first tx mismatch %0d", d, f, i);
    end
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; wf = 8'h00; adder = 32'h0;
    test_reset;
    test_basic;
    test_checksum_wrap;
    test_snapshot;
    test_random_frames;
    test_back_to_back;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
